// File: rtl/led_breathe_multi.sv
// N-channel PWM breathing LED driver: one shared PWM counter and step prescaler
// drive per-channel brightness ramps (triangle / sawtooth / hold / off).
module led_breathe_multi #(
    parameter int CHANNELS      = 4,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 200000,
    parameter int PRESCALE_BITS = 18
) (
    input  logic                         sysclk,
    input  logic                         sys_rst_n,
    input  logic                         enable,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic [PWM_BITS*CHANNELS-1:0] peak,
    output logic [CHANNELS-1:0]          led,
    output logic [PWM_BITS*CHANNELS-1:0] bright,
    output logic                         tick
);

    localparam logic [PRESCALE_BITS-1:0] RELOAD = PRESCALE_BITS'(PRESCALE - 1);

    localparam logic [1:0] MODE_TRI  = 2'b00;
    localparam logic [1:0] MODE_SAW  = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b10;

    logic [PWM_BITS-1:0]          pwm_ctr;
    logic [PRESCALE_BITS-1:0]     step_ctr;
    logic [CHANNELS-1:0]          dir;
    logic [CHANNELS-1:0]          dir_nxt;
    logic [PWM_BITS*CHANNELS-1:0] bright_nxt;

    // Returns {dir, bright} after one step; guards keep +1/-1 from wrapping.
    function automatic logic [PWM_BITS:0] step_fn(
        input logic [1:0]          m,
        input logic [PWM_BITS-1:0] pk,
        input logic [PWM_BITS-1:0] b,
        input logic                d
    );
        logic [PWM_BITS:0] r;
        case (m)
            MODE_TRI: begin
                if (d) r = (b < pk) ? {1'b1, b + PWM_BITS'(1)} : {1'b0, b};
                else   r = (b != '0) ? {1'b0, b - PWM_BITS'(1)} : {1'b1, b};
            end
            MODE_SAW:  r = (b < pk) ? {1'b1, b + PWM_BITS'(1)} : {1'b1, {PWM_BITS{1'b0}}};
            MODE_HOLD: r = {1'b1, pk};
            default:   r = {1'b1, {PWM_BITS{1'b0}}};
        endcase
        return r;
    endfunction

    assign tick = enable && (step_ctr == '0);

    always_comb begin
        bright_nxt = bright;
        dir_nxt    = dir;
        for (int i = 0; i < CHANNELS; i++) begin
            {dir_nxt[i], bright_nxt[i*PWM_BITS +: PWM_BITS]} =
                step_fn(mode[2*i +: 2], peak[i*PWM_BITS +: PWM_BITS],
                        bright[i*PWM_BITS +: PWM_BITS], dir[i]);
        end
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_ctr  <= '0;
            step_ctr <= RELOAD;
            bright   <= '0;
            dir      <= '1;
            led      <= '0;
        end else begin
            pwm_ctr <= pwm_ctr + PWM_BITS'(1);
            if (!enable || step_ctr == '0) step_ctr <= RELOAD;
            else                           step_ctr <= step_ctr - PRESCALE_BITS'(1);
            for (int i = 0; i < CHANNELS; i++) begin
                led[i] <= enable && (pwm_ctr < bright[i*PWM_BITS +: PWM_BITS]);
            end
            if (tick) begin
                bright <= bright_nxt;
                dir    <= dir_nxt;
            end
        end
    end

endmodule

// File: tb/tb_led_breathe_multi.sv
// Bench for led_breathe_multi: per-cycle reference model plus table-driven and
// hand-written sequences for ramp shapes, reset, enable and peak changes.
module tb_led_breathe_multi;

    localparam int CH = 2;
    localparam int PB = 4;
    localparam int PS = 4;

    logic            sysclk = 1'b0;
    logic            sys_rst_n;
    logic            enable;
    logic [2*CH-1:0] mode;
    logic [PB*CH-1:0] peak;
    logic [CH-1:0]   led;
    logic [PB*CH-1:0] bright;
    logic            tick;

    led_breathe_multi #(.CHANNELS(CH), .PWM_BITS(PB), .PRESCALE(PS), .PRESCALE_BITS(2)) dut (
        .sysclk(sysclk), .sys_rst_n(sys_rst_n), .enable(enable), .mode(mode),
        .peak(peak), .led(led), .bright(bright), .tick(tick)
    );

    always #5 sysclk = ~sysclk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: time-based view of the prescaler (enabled run length)
    int m_pwm, m_run;
    int m_br[CH];
    bit m_dir[CH];
    bit m_led[CH];
    bit m_tick;
    logic last_tick;

    typedef struct {
        logic [1:0] md;
        logic [3:0] pk;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pwm = 0;
        m_run = 0;
        for (int i = 0; i < CH; i++) begin
            m_br[i] = 0; m_dir[i] = 1; m_led[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < CH; i++) begin
            int md, pk;
            md = int'(mode[2*i +: 2]);
            pk = int'(peak[PB*i +: PB]);
            m_led[i] = enable && (m_pwm < m_br[i]);
            if (m_tick) begin
                case (md)
                    0: if (m_dir[i]) begin
                           if (m_br[i] < pk) m_br[i]++; else m_dir[i] = 0;
                       end else begin
                           if (m_br[i] > 0) m_br[i]--; else m_dir[i] = 1;
                       end
                    1: begin m_br[i] = (m_br[i] < pk) ? m_br[i] + 1 : 0; m_dir[i] = 1; end
                    2: begin m_br[i] = pk; m_dir[i] = 1; end
                    default: begin m_br[i] = 0; m_dir[i] = 1; end
                endcase
            end
        end
        m_pwm = (m_pwm + 1) % (1 << PB);
        m_run = enable ? m_run + 1 : 0;
    endtask

    // One clock cycle: called just after a falling edge with inputs already driven.
    task automatic cyc();
        #1;
        m_tick = enable && ((m_run % PS) == PS - 1);
        last_tick = tick;
        chk("tick", 32'(tick), 32'(m_tick));
        @(posedge sysclk);
        model_edge();
        @(negedge sysclk);
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("led%0d", i), 32'(led[i]), 32'(m_led[i]));
            chk($sformatf("bright%0d", i), 32'(bright[PB*i +: PB]), 32'(m_br[i]));
        end
    endtask

    task automatic run_to_tick(output int n);
        bit seen;
        seen = 0;
        n = 0;
        for (int k = 0; k < 64 && !seen; k++) begin
            cyc();
            n = k + 1;
            if (last_tick === 1'b1) seen = 1;
        end
        if (!seen) chk("tick_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        #1;
        chk("rst_led", 32'(led), 32'(0));
        chk("rst_bright", 32'(bright), 32'(0));
        chk("rst_tick", 32'(tick), 32'(0));
        model_reset();
        @(negedge sysclk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int n, cnt0, cnt1;
        int e0[4], e1[4];
        sys_rst_n = 1'b1;
        enable    = 1'b1;
        mode      = 4'b1100;
        peak      = 8'h33;
        #2;
        do_reset();

        // Tick cadence after reset
        run_to_tick(n); chk("first_tick_cycles", 32'(n), 32'(PS));
        run_to_tick(n); chk("next_tick_cycles", 32'(n), 32'(PS));
        do_reset();

        // Triangle then sawtooth on channel 0, peak 3; channel 1 off
        tbl[0]  = '{2'b00, 4'd3, 4'd1}; tbl[1]  = '{2'b00, 4'd3, 4'd2};
        tbl[2]  = '{2'b00, 4'd3, 4'd3}; tbl[3]  = '{2'b00, 4'd3, 4'd3};
        tbl[4]  = '{2'b00, 4'd3, 4'd2}; tbl[5]  = '{2'b00, 4'd3, 4'd1};
        tbl[6]  = '{2'b00, 4'd3, 4'd0}; tbl[7]  = '{2'b00, 4'd3, 4'd0};
        tbl[8]  = '{2'b00, 4'd3, 4'd1}; tbl[9]  = '{2'b01, 4'd3, 4'd2};
        tbl[10] = '{2'b01, 4'd3, 4'd3}; tbl[11] = '{2'b01, 4'd3, 4'd0};
        tbl[12] = '{2'b01, 4'd3, 4'd1}; tbl[13] = '{2'b01, 4'd3, 4'd2};
        tbl[14] = '{2'b01, 4'd3, 4'd3}; tbl[15] = '{2'b01, 4'd3, 4'd0};
        for (int v = 0; v < 16; v++) begin
            mode = {2'b11, tbl[v].md};
            peak = {4'd0, tbl[v].pk};
            run_to_tick(n);
            chk($sformatf("tbl%0d_bright0", v), 32'(bright[3:0]), 32'(tbl[v].exp));
        end

        // Hold peak 5 on channel 0, off on channel 1: duty 5/16 and 0/16
        mode = 4'b1110;
        peak = 8'h95;
        run_to_tick(n);
        cyc();
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 16; k++) begin
            cyc();
            cnt0 += int'(led[0]);
            cnt1 += int'(led[1]);
        end
        chk("hold5_led_count", 32'(cnt0), 32'(5));
        chk("off_led_count", 32'(cnt1), 32'(0));

        // Mid-run reset, then cadence again
        #2;
        do_reset();
        run_to_tick(n); chk("post_reset_tick_cycles", 32'(n), 32'(PS));

        // Peak lowered below rising triangle on channel 0 only
        do_reset();
        mode = 4'b0000;
        peak = 8'hAA;
        for (int k = 0; k < 7; k++) run_to_tick(n);
        chk("tri_at7", 32'(bright[3:0]), 32'(7));
        peak = 8'hA4;
        e0 = '{7, 6, 5, 4};
        e1 = '{8, 9, 10, 10};
        for (int k = 0; k < 4; k++) begin
            run_to_tick(n);
            chk($sformatf("peakdrop_ch0_%0d", k), 32'(bright[3:0]), 32'(e0[k]));
            chk($sformatf("peakdrop_ch1_%0d", k), 32'(bright[7:4]), 32'(e1[k]));
        end

        // Enable freeze at bright 6 and resume
        do_reset();
        mode = 4'b0000;
        peak = 8'hFF;
        for (int k = 0; k < 6; k++) run_to_tick(n);
        enable = 1'b0;
        cyc();
        chk("disable_led", 32'(led), 32'(0));
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("frozen_tick", 32'(last_tick), 32'(0));
            chk("frozen_bright0", 32'(bright[3:0]), 32'(6));
        end
        enable = 1'b1;
        run_to_tick(n);
        chk("resume_tick_cycles", 32'(n), 32'(PS));
        chk("resume_bright0", 32'(bright[3:0]), 32'(7));

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) mode = 4'($urandom);
            if ($urandom_range(0, 9) == 0) peak = 8'($urandom);
            enable = ($urandom_range(0, 7) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
